// File: rtl/mips_muldiv_hilo_pkg.sv
// Shared widths, FSM encoding and operand-magnitude helper for the HI/LO multiply controller.
package mips_muldiv_hilo_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MULT_HALF = 16;
    localparam int unsigned PP_W      = 48;
    localparam int unsigned PROD_W    = 64;

    // Sequencer states: idle, low partial product, high partial product, combine
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLO  = 2'd1;
    localparam logic [1:0] ST_PHI  = 2'd2;
    localparam logic [1:0] ST_COMB = 2'd3;

    // Two's-complement magnitude; 0x80000000 maps to itself and is then treated as unsigned
    function automatic logic [DATA_W-1:0] op_mag(input logic [DATA_W-1:0] x, input logic neg);
        return neg ? DATA_W'(-x) : x;
    endfunction

endpackage

// File: rtl/mips_mult.sv
// Multiplier datapath stage: 16x32 partial product and final combine/negate of two partials.
module mips_mult
    import mips_muldiv_hilo_pkg::*;
(
    input  logic [MULT_HALF-1:0] a,
    input  logic [DATA_W-1:0]    b,
    output logic [PP_W-1:0]      partproduct,
    input  logic [PP_W-1:0]      partprod_l,
    input  logic [PP_W-1:0]      partprod_h,
    input  logic                 acompl,
    input  logic                 bcompl,
    output logic [PROD_W-1:0]    product
);

    logic [PP_W-1:0]   sum_c;
    logic [PROD_W-1:0] mag_c;

    // Partial product, weighted combine of the two halves, and sign restoration
    always_comb begin
        partproduct = PP_W'(a) * PP_W'(b);
        sum_c       = partprod_h + PP_W'(partprod_l[PP_W-1:MULT_HALF]);
        mag_c       = {sum_c, partprod_l[MULT_HALF-1:0]};
        product     = (acompl ^ bcompl) ? PROD_W'(-mag_c) : mag_c;
    end

endmodule

// File: rtl/mips_muldiv_hilo.sv
// Multiply sequencer and architectural HI/LO owner; also handles MTHI/MTLO.
module mips_muldiv_hilo
    import mips_muldiv_hilo_pkg::*;
#(
    parameter logic [31:0] HI_RST = 32'h0,
    parameter logic [31:0] LO_RST = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sign,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              cancel,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    logic [1:0]           state_q, state_d;
    logic [DATA_W-1:0]    abs_a_q, abs_b_q;
    logic                 acompl_q, bcompl_q;
    logic [PP_W-1:0]      pp_l_q, pp_h_q;
    logic [DATA_W-1:0]    hi_q, lo_q;
    logic                 done_q;

    logic                 accept_c;
    logic                 commit_c;
    logic [MULT_HALF-1:0] stage_a_c;
    logic [PP_W-1:0]      partproduct_c;
    logic [PROD_W-1:0]    product_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; cancel aborts any busy state and blocks a start in IDLE
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        commit_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    state_d  = ST_PLO;
                    accept_c = 1'b1;
                end
            end
            ST_PLO:  state_d = cancel ? ST_IDLE : ST_PHI;
            ST_PHI:  state_d = cancel ? ST_IDLE : ST_COMB;
            ST_COMB: begin
                state_d  = ST_IDLE;
                commit_c = !cancel;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Low half of the multiplicand first, then the high half
    always_comb begin
        stage_a_c = (state_q == ST_PHI) ? abs_a_q[DATA_W-1:MULT_HALF] : abs_a_q[MULT_HALF-1:0];
    end

    mips_mult u_mult (
        .a           (stage_a_c),
        .b           (abs_b_q),
        .partproduct (partproduct_c),
        .partprod_l  (pp_l_q),
        .partprod_h  (pp_h_q),
        .acompl      (acompl_q),
        .bcompl      (bcompl_q),
        .product     (product_c)
    );

    // Operand magnitudes and sign flags captured on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abs_a_q  <= '0;
            abs_b_q  <= '0;
            acompl_q <= 1'b0;
            bcompl_q <= 1'b0;
        end else if (accept_c) begin
            abs_a_q  <= op_mag(op_a, sign & op_a[DATA_W-1]);
            abs_b_q  <= op_mag(op_b, sign & op_b[DATA_W-1]);
            acompl_q <= sign & op_a[DATA_W-1];
            bcompl_q <= sign & op_b[DATA_W-1];
        end
    end

    // Partial-product capture in the two product cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_l_q <= '0;
            pp_h_q <= '0;
        end else begin
            if (state_q == ST_PLO) pp_l_q <= partproduct_c;
            if (state_q == ST_PHI) pp_h_q <= partproduct_c;
        end
    end

    // HI/LO: product commit, or MTHI/MTLO only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= HI_RST;
            lo_q   <= LO_RST;
            done_q <= 1'b0;
        end else begin
            done_q <= commit_c;
            if (commit_c) begin
                hi_q <= product_c[PROD_W-1:DATA_W];
                lo_q <= product_c[DATA_W-1:0];
            end else if (state_q == ST_IDLE) begin
                if (mthi) hi_q <= wdata;
                if (mtlo) lo_q <= wdata;
            end
        end
    end

    // Interlock is a direct decode of the sequencer state
    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_hilo.sv
// Directed bench for the HI/LO multiply controller.
module tb_mips_muldiv_hilo;

    localparam logic [31:0] HI_R = 32'hCAFE_0001;
    localparam logic [31:0] LO_R = 32'hBEEF_0002;

    typedef struct packed {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic        sign   = 1'b0;
    logic        cancel = 1'b0;
    logic        mthi   = 1'b0;
    logic        mtlo   = 1'b0;
    logic [31:0] op_a   = '0;
    logic [31:0] op_b   = '0;
    logic [31:0] wdata  = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;
    vec_t vecs[4];
    int   npulse;

    mips_muldiv_hilo #(.HI_RST(HI_R), .LO_RST(LO_R)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sign   (sign),
        .op_a   (op_a),
        .op_b   (op_b),
        .cancel (cancel),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Issues one multiply and checks busy in cycles 1-3 and result/done in cycle 4; returns in cycle 4
    task automatic run_mult(input string nm, input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el);
        sign = s; op_a = a; op_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk1($sformatf("%s busy c%0d", nm, c), busy, 1'b1);
            chk1($sformatf("%s done c%0d", nm, c), done, 1'b0);
            tick();
        end
        chk1({nm, " done"}, done, 1'b1);
        chk1({nm, " busy_end"}, busy, 1'b0);
        chk32({nm, " hi"}, hi, eh);
        chk32({nm, " lo"}, lo, el);
        mdl_hi = eh;
        mdl_lo = el;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3] = '{1'b1, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000};

        // Reset values
        #12;
        chk32("rst hi", hi, HI_R);
        chk32("rst lo", lo, LO_R);
        chk1("rst busy", busy, 1'b0);
        chk1("rst done", done, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Table of directed products
        for (int i = 0; i < 4; i++) begin
            run_mult($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el);
            tick();
        end

        // Cancel during PHI
        sign = 1'b0; op_a = 32'd7; op_b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk1("cancel_phi busy", busy, 1'b0);
        chk1("cancel_phi done", done, 1'b0);
        tick();
        chk1("cancel_phi done_late", done, 1'b0);
        chk32("cancel_phi hi", hi, mdl_hi);
        chk32("cancel_phi lo", lo, mdl_lo);

        // Cancel during COMB suppresses the write
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk1("cancel_comb done", done, 1'b0);
        chk32("cancel_comb hi", hi, mdl_hi);
        chk32("cancel_comb lo", lo, mdl_lo);

        // Cancel together with start in IDLE drops the start
        start = 1'b1; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        chk1("cancel_start busy", busy, 1'b0);
        tick();

        // mthi and a second start while busy are both ignored
        sign = 1'b0; op_a = 32'd7; op_b = 32'd9; start = 1'b1;
        tick();
        start = 1'b1; mthi = 1'b1; wdata = 32'h0000_1234; op_a = 32'd100;
        tick();
        start = 1'b0; mthi = 1'b0;
        chk32("mthi_busy hi", hi, mdl_hi);
        tick();
        tick();
        chk1("one_pulse done", done, 1'b1);
        chk32("busy_ops hi", hi, 32'h0);
        chk32("busy_ops lo", lo, 32'd63);
        npulse = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done) npulse++;
        end
        chk32("extra_done count", 32'(npulse), 32'd0);

        // mtlo in IDLE, then mthi+mtlo together
        mtlo = 1'b1; wdata = 32'h0000_ABCD;
        tick();
        mtlo = 1'b0;
        chk32("mtlo lo", lo, 32'h0000_ABCD);
        chk32("mtlo hi", hi, 32'h0);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_0077;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        chk32("mthilo hi", hi, 32'h77);
        chk32("mthilo lo", lo, 32'h77);

        // mthi in the start cycle: takes effect, then the product overwrites HI
        mthi = 1'b1; wdata = 32'h0000_5555;
        sign = 1'b0; op_a = 32'd2; op_b = 32'd3; start = 1'b1;
        tick();
        mthi = 1'b0; start = 1'b0;
        chk32("mthi_start hi_mid", hi, 32'h5555);
        tick();
        tick();
        tick();
        chk1("mthi_start done", done, 1'b1);
        chk32("mthi_start hi", hi, 32'h0);
        chk32("mthi_start lo", lo, 32'd6);
        tick();

        // Back-to-back: second start issued in the done cycle
        run_mult("b2b_first", 1'b0, 32'd3, 32'd4, 32'h0, 32'd12);
        run_mult("b2b_second", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
        tick();

        // Reset in the middle of PHI
        sign = 1'b0; op_a = 32'd5; op_b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk32("rst_mid hi", hi, HI_R);
        chk32("rst_mid lo", lo, LO_R);
        chk1("rst_mid busy", busy, 1'b0);
        chk1("rst_mid done", done, 1'b0);
        tick();
        rst_n = 1'b1;
        npulse = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done || busy) npulse++;
        end
        chk32("rst_mid after", 32'(npulse), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_hilo.md
Name: mips_muldiv_hilo

Overview:
- Sequencing controller for the multicycle multiplier and owner of the architectural HI/LO registers.
- Accepts MULT/MULTU from the execute stage and drives the mips_mult stage over two partial-product cycles plus one combine cycle.
- Writes the 64-bit result into HI/LO.
- Also services MTHI/MTLO and exposes busy for the pipeline interlock.

Parameters:
- HI_RST, 32'h0, reset value of HI.
- LO_RST, 32'h0, reset value of LO.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- sign  input  1  1 = MULT (signed), 0 = MULTU.
- op_a  input  32  multiplicand (rs).
- op_b  input  32  multiplier (rt).
- cancel  input  1  abort the in-flight multiply (pipeline flush/exception).
- mthi  input  1  write wdata to HI.
- mtlo  input  1  write wdata to LO.
- wdata  input  32  MTHI/MTLO data.
- busy  output  1  multiply in flight.
- done  output  1  one-cycle pulse: HI/LO hold a new product.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (async, rst_n=0):
  - State to IDLE.
  - hi=HI_RST, lo=LO_RST.
  - busy=0, done=0.
  - Operand and partial-product registers cleared.
- FSM states: IDLE, PLO, PHI, COMB.
- IDLE:
  - start=1 and cancel=0: latch abs_a and abs_b, then go to PLO.
  - In signed mode, abs_x = two's-complement magnitude of a negative operand; otherwise abs_x = op_x.
  - acompl = sign & op_a[31]; bcompl = sign & op_b[31].
  - 0x80000000 yields magnitude 0x80000000, treated as unsigned.
- PLO: stage a = abs_a[15:0], b = abs_b. pp_l <= partproduct (48 bits). Go to PHI.
- PHI: stage a = abs_a[31:16], b = abs_b. pp_h <= partproduct. Go to COMB.
- COMB:
  - Stage partprod_l = pp_l, partprod_h = pp_h, acompl/bcompl as latched.
  - {hi,lo} <= product; done <= 1 for the next cycle only. Go to IDLE.
- busy = 1 in PLO, PHI and COMB (combinational decode of state).
- Latency: start sampled at edge 0; hi/lo updated and done=1 in cycle 4 (after edge 3). Back-to-back start is accepted in the cycle done is high.
- start while busy: ignored; no queueing.
- cancel:
  - In any busy state: return to IDLE at the next edge, hi/lo unchanged, no done pulse.
  - cancel in COMB suppresses the HI/LO write.
  - cancel with start in IDLE: cancel wins, start is dropped.
- mthi/mtlo:
  - Honoured only when busy=0, at the next edge.
  - While busy they are ignored (MIPS hazard made deterministic).
  - mthi and start in the same IDLE cycle: both take effect; the later product overwrites HI.
  - mthi and mtlo together: both write wdata.
- Reset mid-operation: immediate abort to the reset values above; no done.
- Width rules:
  - Partial products are 48 bits.
  - Combine: pp_h + pp_l[47:16], concatenated with pp_l[15:0].
  - Negation is applied when acompl ^ bcompl. All of this is inside mips_mult; the controller adds no arithmetic beyond operand magnitude.

Decomposition:
- Shared package holds:
  - the FSM state encoding (2-bit: IDLE=0, PLO=1, PHI=2, COMB=3);
  - widths MULT_HALF=16 and PP_W=48.
- One sub-module, instantiated once: the existing mips_mult stage.
- Operand-magnitude logic stays inline.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> busy high cycles 1-3, done in cycle 4, hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 * 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0x00000000. MULT 0x80000000 * 2 -> hi=0xFFFFFFFF, lo=0x00000000.
- Start MULTU 7*9, assert cancel in PHI -> state IDLE next cycle, no done, hi/lo keep prior values.
- mthi wdata=0x1234 during PLO -> HI unchanged. mtlo wdata=0xABCD in IDLE -> lo=0xABCD next cycle. Second start during busy -> ignored, exactly one done pulse.
- Back-to-back: start in done cycle with MULT -1*-1 -> second done 4 cycles later, hi=0, lo=1. rst_n low mid-PHI -> hi/lo=reset values, busy=0.
